// File: rtl/ov7670_sccb_init_seq.sv
// ov7670_sccb_init_seq: Wishbone master that sets up an I2C master core, then streams a {reg,val} ROM to an OV7670 over SCCB.
// Define SCCB_VERIFY_EN to read back every written register and flag mismatches; the default build is write-only.
module ov7670_sccb_init_seq #(
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter logic [6:0]  SLAVE_ADDR = 7'h21,
    parameter int          ROM_AW     = 8,
    parameter logic [23:0] RST_DELAY  = 24'd50000,
    parameter logic [15:0] POLL_LIMIT = 16'd4095
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ROM_AW-1:0] err_idx_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic [2:0]        wbm_adr_o,
    output logic [7:0]        wbm_dat_o,
    input  logic [7:0]        wbm_dat_i,
    output logic              wbm_we_o,
    output logic              wbm_stb_o,
    output logic              wbm_cyc_o,
    input  logic              wbm_ack_i
);
    typedef enum logic [4:0] {
        IDLE, CFG_PLO, CFG_PHI, CFG_CTR, FETCH, DECODE, WR_TXR, WR_CR,
        GUARD, POLL, CHECK, DELAY, ADV, FINISH
`ifdef SCCB_VERIFY_EN
        , RD_RXR
`endif
    } state_t;

    // Phases 0-2 write an entry, 3-6 read it back, STO is the abort stop.
    localparam logic [2:0] STO = 3'd7;

    state_t      state, state_n;
    logic [2:0]  phase, phase_n;
    logic [23:0] cnt;
    logic [7:0]  reg_q, val_q, txr_byte, cr_byte;
    logic        gap, rx_nack, acc, rd, bus, set_err, rst_entry, unused_sr;

    assign acc       = wbm_cyc_o & wbm_ack_i;
    assign rst_entry = reg_q == 8'h12 && val_q[7];
    assign unused_sr = ^{wbm_dat_i[6:2], wbm_dat_i[0]};
`ifdef SCCB_VERIFY_EN
    assign rd = state == POLL || state == RD_RXR;
`else
    assign rd = state == POLL;
`endif
    assign bus      = rd || state inside {CFG_PLO, CFG_PHI, CFG_CTR, WR_TXR, WR_CR};
    assign txr_byte = phase == 3'd1 || phase == 3'd4 ? reg_q : phase == 3'd2 ? val_q :
                      {SLAVE_ADDR, phase == 3'd5};
    assign cr_byte  = phase == 3'd1 ? 8'h10 : phase == 3'd2 || phase == 3'd4 ? 8'h50 :
                      phase == 3'd6 ? 8'h68 : phase == STO ? 8'h40 : 8'h90;

    // The cycle after an ack is always idle, so gap masks the strobe for one cycle.
    assign wbm_cyc_o = bus && !gap;
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = wbm_cyc_o && !rd;
    assign wbm_adr_o = !wbm_cyc_o ? 3'd0 : state == CFG_PLO ? 3'd0 : state == CFG_PHI ? 3'd1 :
                       state == CFG_CTR ? 3'd2 : state == WR_CR || state == POLL ? 3'd4 : 3'd3;
    assign wbm_dat_o = !wbm_we_o ? 8'h00 : state == CFG_PLO ? PRESCALE[7:0] :
                       state == CFG_PHI ? PRESCALE[15:8] : state == CFG_CTR ? 8'h80 :
                       state == WR_TXR ? txr_byte : cr_byte;
    assign busy_o    = state != IDLE && state != FINISH;

    // State register; reset drops any bus cycle on the same edge without a STOP.
    always_ff @(posedge wb_clk_i) state <= wb_rst_i ? IDLE : state_n;

    // Sequencing decisions: bus handshakes, SR polling, entry walking and abort path.
    always_comb begin
        state_n = state;
        phase_n = phase;
        set_err = 1'b0;
        case (state)
            IDLE:    if (start_i) state_n = CFG_PLO;
            CFG_PLO: if (acc) state_n = CFG_PHI;
            CFG_PHI: if (acc) state_n = CFG_CTR;
            CFG_CTR: if (acc) state_n = FETCH;
            FETCH:   state_n = DECODE;
            DECODE:  begin
                state_n = &rom_data_i ? FINISH : WR_TXR;
                phase_n = 3'd0;
            end
            WR_TXR:  if (acc) state_n = WR_CR;
            WR_CR:   if (acc) state_n = GUARD;
            GUARD:   if (cnt == 24'd1) state_n = POLL;
            POLL: begin
                if (acc && !wbm_dat_i[1]) state_n = CHECK;
                else if (acc && cnt == 24'(POLL_LIMIT) - 24'd1) begin
                    state_n = phase == STO ? FINISH : WR_CR;
                    set_err = phase == STO;
                    phase_n = STO;
                end
            end
            CHECK: begin
                if (phase == STO) begin
                    set_err = 1'b1;
                    state_n = FINISH;
                end else if (rx_nack && phase != 3'd6) begin
                    state_n = WR_CR;
                    phase_n = STO;
                end
`ifdef SCCB_VERIFY_EN
                else if (phase == 3'd6) state_n = RD_RXR;
                else if (phase == 3'd2 && !rst_entry) begin
                    state_n = WR_TXR;
                    phase_n = 3'd3;
                end else if (phase == 3'd5) begin
                    state_n = WR_CR;
                    phase_n = 3'd6;
                end
`endif
                else if (phase == 3'd2) state_n = rst_entry ? DELAY : ADV;
                else begin
                    state_n = WR_TXR;
                    phase_n = phase + 3'd1;
                end
            end
`ifdef SCCB_VERIFY_EN
            RD_RXR: if (acc) begin
                set_err = wbm_dat_i != val_q;
                state_n = ADV;
            end
`endif
            DELAY:   if (cnt == RST_DELAY - 24'd1) state_n = ADV;
            ADV:     state_n = &rom_addr_o ? FINISH : FETCH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: counters restart on every state change, POLL counts acked SR reads only.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            {done_o, err_o, err_idx_o, rom_addr_o} <= '0;
            {phase, cnt, reg_q, val_q, gap, rx_nack} <= '0;
        end else begin
            gap   <= acc;
            phase <= phase_n;
            cnt   <= state_n != state ? '0 : cnt + (state == POLL ? 24'(acc) : 24'd1);
            if (state == POLL && acc) rx_nack <= wbm_dat_i[7];
            if (state == DECODE) {reg_q, val_q} <= rom_data_i;
            if (state == ADV && state_n == FETCH) rom_addr_o <= rom_addr_o + 1'b1;
            if (state == FINISH) done_o <= 1'b1;
            if (set_err) begin
                err_o <= 1'b1;
                if (!err_o) err_idx_o <= rom_addr_o;
            end
            if (state == IDLE && start_i) {done_o, err_o, err_idx_o, rom_addr_o} <= '0;
        end
    end
endmodule

// File: tb/tb_ov7670_sccb_init_seq.sv
// tb_ov7670_sccb_init_seq: scoreboard bench with an I2C-core bus model for the SCCB init sequencer.
module tb_ov7670_sccb_init_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic        busy, done, err, we, stb, cyc, ack;
    logic [7:0]  err_idx, rom_addr, dato, dati;
    logic [2:0]  adr;
    logic [15:0] rom_data;
    logic [15:0] rom [0:255];
    logic [7:0]  cam [0:255];
    logic [7:0]  txr, cur_reg, nack_reg;
    logic [1:0]  bidx;
    logic        rd_addr, nack_now, sto_seen, nack_en = 1'b0, tip_stuck = 1'b0, corrupt_en = 1'b0;
    logic [10:0] exp_q [$];
    int          checks = 0, failures = 0, max_gap = 0, sto_reads = 0;

    ov7670_sccb_init_seq dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .err_idx_o(err_idx), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_dat_i(dati), .wbm_we_o(we),
        .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_ack_i(ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    // I2C core model: single-cycle ack, tracks register/value bytes to answer SR and RXR reads.
    assign ack  = cyc & stb;
    assign dati = adr == 3'd4 ? {nack_now, 5'd0, tip_stuck && !sto_seen, 1'b0} :
                  adr == 3'd3 ? ((corrupt_en && cur_reg == 8'h11) ? 8'h02 : cam[cur_reg]) : 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            {txr, cur_reg, bidx, rd_addr, nack_now, sto_seen} <= '0;
        end else if (cyc && stb && we) begin
            if (adr == 3'd0) sto_seen <= 1'b0;
            if (adr == 3'd3) txr <= dato;
            if (adr == 3'd4) begin
                nack_now <= 1'b0;
                if (dato == 8'h40) sto_seen <= 1'b1;
                if (dato[7]) begin
                    bidx    <= 2'd0;
                    rd_addr <= txr[0];
                end else if (dato[4]) begin
                    bidx <= bidx + 2'd1;
                    if (!rd_addr && bidx == 2'd0) begin
                        cur_reg  <= txr;
                        nack_now <= nack_en && txr == nack_reg;
                    end
                    if (!rd_addr && bidx == 2'd1) cam[cur_reg] <= txr;
                end
            end
        end
    end

    // Monitor: pops the expected write stream on every acked write, gathers timing and SR-read stats.
    initial begin
        logic [10:0] e;
        int cyc_n = 0, last_acc = 0, sr_reads = 0;
        logic busy_d = 1'b0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (busy && !busy_d) begin
                last_acc = cyc_n;
                max_gap  = 0;
            end
            busy_d = busy;
            if (cyc && stb) begin
                if (cyc_n - last_acc > max_gap) max_gap = cyc_n - last_acc;
                last_acc = cyc_n;
                if (!we && adr == 3'd4) sr_reads++;
                if (we) begin
                    if (adr == 3'd4 && dato == 8'h40) sto_reads = sr_reads;
                    if (adr == 3'd4) sr_reads = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL wr_unexpected got=%0d/%02h required=none", adr, dato);
                    end else begin
                        e = exp_q.pop_front();
                        if (e != {adr, dato}) begin
                            failures++;
                            $display("FAIL wr_seq got=%0d/%02h required=%0d/%02h", adr, dato, e[10:8], e[7:0]);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_cfg();
        push_wr(3'd0, 8'h63);
        push_wr(3'd1, 8'h00);
        push_wr(3'd2, 8'h80);
    endtask

    task automatic push_entry(input logic [7:0] r, input logic [7:0] v);
        push_wr(3'd3, 8'h42); push_wr(3'd4, 8'h90);
        push_wr(3'd3, r);     push_wr(3'd4, 8'h10);
        push_wr(3'd3, v);     push_wr(3'd4, 8'h50);
`ifdef SCCB_VERIFY_EN
        if (!(r == 8'h12 && v[7])) begin
            push_wr(3'd3, 8'h42); push_wr(3'd4, 8'h90);
            push_wr(3'd3, r);     push_wr(3'd4, 8'h50);
            push_wr(3'd3, 8'h43); push_wr(3'd4, 8'h90);
            push_wr(3'd4, 8'h68);
        end
`endif
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", done, 1);
    endtask

    initial begin
        int n;
        clear_rom();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_idx", err_idx, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_cyc", {cyc, stb, we}, 0);
        rst = 1'b0;

        // 1: reset-register entry forces the long delay, then a normal entry
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        push_cfg(); push_entry(8'h12, 8'h80); push_entry(8'h11, 8'h01);
        pulse_start();
        wait_done(70000);
        check("t1_err", err, 0);
        check("t1_addr", rom_addr, 2);
        check("t1_delay", max_gap >= 50000, 1);
        check("t1_queue", exp_q.size(), 0);

        // 2: NACK on the register byte of entry 3
        clear_rom();
        rom[0] = 16'h3A04; rom[1] = 16'h1101; rom[2] = 16'h40D0; rom[3] = 16'h1713; rom[4] = 16'h1801;
        nack_reg = 8'h17; nack_en = 1'b1;
        push_cfg(); push_entry(8'h3A, 8'h04); push_entry(8'h11, 8'h01); push_entry(8'h40, 8'hD0);
        push_wr(3'd3, 8'h42); push_wr(3'd4, 8'h90); push_wr(3'd3, 8'h17); push_wr(3'd4, 8'h10);
        push_wr(3'd4, 8'h40);
        pulse_start();
        wait_done(20000);
        check("t2_err", err, 1);
        check("t2_idx", err_idx, 3);
        check("t2_addr", rom_addr, 3);
        check("t2_queue", exp_q.size(), 0);
        nack_en = 1'b0;

        // 3: TIP never clears, timeout after the poll limit
        clear_rom();
        rom[0] = 16'h3A04;
        tip_stuck = 1'b1;
        push_cfg(); push_wr(3'd3, 8'h42); push_wr(3'd4, 8'h90); push_wr(3'd4, 8'h40);
        pulse_start();
        wait_done(20000);
        check("t3_err", err, 1);
        check("t3_idx", err_idx, 0);
        check("t3_sr_reads", sto_reads, 4095);
        check("t3_queue", exp_q.size(), 0);
        tip_stuck = 1'b0;

        // 4: reset while polling entry 1
        clear_rom();
        rom[0] = 16'h3A04; rom[1] = 16'h1101;
        push_cfg(); push_entry(8'h3A, 8'h04); push_wr(3'd3, 8'h42); push_wr(3'd4, 8'h90);
        pulse_start();
        n = 0;
        while (!(rom_addr == 8'd1 && cyc && !we && adr == 3'd4) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("t4_poll_reached", n < 3000, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t4_cyc", {cyc, stb}, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_addr", rom_addr, 0);
        check("t4_queue", exp_q.size(), 0);
        rst = 1'b0;

        // 5: start while busy is ignored; start after done clears and reruns
        clear_rom();
        rom[0] = 16'h3A04;
        push_cfg(); push_entry(8'h3A, 8'h04);
        pulse_start();
        repeat (8) @(negedge clk);
        check("t5_busy", busy, 1);
        pulse_start();
        wait_done(5000);
        check("t5_err", err, 0);
        check("t5_queue1", exp_q.size(), 0);
        push_cfg(); push_entry(8'h3A, 8'h04);
        pulse_start();
        check("t5_done_clr", done, 0);
        check("t5_rerun_busy", busy, 1);
        wait_done(5000);
        check("t5_queue2", exp_q.size(), 0);

`ifdef SCCB_VERIFY_EN
        // 6: readback mismatch on reg 0x11 flags but does not stop the walk
        clear_rom();
        rom[0] = 16'h3A04; rom[1] = 16'h1101; rom[2] = 16'h40D0;
        corrupt_en = 1'b1;
        push_cfg(); push_entry(8'h3A, 8'h04); push_entry(8'h11, 8'h01); push_entry(8'h40, 8'hD0);
        pulse_start();
        wait_done(10000);
        check("t6_err", err, 1);
        check("t6_idx", err_idx, 1);
        check("t6_addr", rom_addr, 3);
        check("t6_queue", exp_q.size(), 0);
        corrupt_en = 1'b0;
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
